// File: rtl/rec_pkg.sv
// Shared types and constants for the recorder capture controller.
package rec_pkg;

    localparam int unsigned DefDw = 24;
    localparam int unsigned SyncStages = 2;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StArm   = 3'd1,
        StRec   = 3'd2,
        StPause = 3'd3,
        StDone  = 3'd4
    } rec_state_e;

endpackage

// File: rtl/rec_capture_ctrl_if.sv
// Sample-buffer write port: request/address/data from the controller, ack from the memory side.
interface rec_capture_ctrl_if
    import rec_pkg::*;
#(
    parameter int unsigned ADDR_W = 20,
    parameter int unsigned DW     = DefDw
) ();

    logic              o_wr_req;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [DW-1:0]     o_wr_data;
    logic              i_wr_ack;

    modport master (
        output o_wr_req,
        output o_wr_addr,
        output o_wr_data,
        input  i_wr_ack
    );

    modport slave (
        input  o_wr_req,
        input  o_wr_addr,
        input  o_wr_data,
        output i_wr_ack
    );

endinterface

// File: rtl/rec_capture_ctrl_lrck_edge_sync.sv
// Multi-flop synchronizer for an asynchronous clock-like input plus a registered
// one-cycle pulse on each synchronized rising edge.
module lrck_edge_sync
    import rec_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  prev_q, prev_d;
    logic                  rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SyncStages-2:0], i_async};
        prev_d = sync_q[SyncStages-1];
        rise_d = sync_q[SyncStages-1] & ~prev_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/rec_capture_ctrl.sv
// Capture sequencer: turns LRCK sample boundaries into delayed, handshaked writes of
// the filtered sample to consecutive buffer addresses, with start/pause/stop control.
module rec_capture_ctrl
    import rec_pkg::*;
#(
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DW          = DefDw,
    parameter int unsigned MAX_SAMPLES = 1048576,
    parameter int unsigned CAPTURE_DLY = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_LRCK,
    input  logic signed [DW-1:0] i_sample,
    input  logic                 i_start,
    input  logic                 i_pause,
    input  logic                 i_stop,
    output logic                 o_rec_en,
    rec_capture_ctrl_if.master   wr,
    output logic [2:0]           o_state,
    output logic [ADDR_W:0]      o_sample_cnt,
    output logic                 o_full,
    output logic                 o_overrun
);

    // Counter holds CAPTURE_DLY-1 so the capture lands exactly CAPTURE_DLY cycles after tick.
    localparam int unsigned DlyW = (CAPTURE_DLY > 1) ? $clog2(CAPTURE_DLY) : 1;
    localparam logic [DlyW-1:0]   DlyLoad = DlyW'(CAPTURE_DLY - 1);
    localparam logic [ADDR_W:0]   MaxCnt  = (ADDR_W + 1)'(MAX_SAMPLES);

    rec_state_e        state_q, state_d;
    logic [DlyW-1:0]   dly_q, dly_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              full_q, full_d;
    logic              overrun_q, overrun_d;
    logic              rec_en_q, rec_en_d;
    logic              start_pend_q, start_pend_d;

    logic            tick;
    logic            xfer;
    logic            capture;
    logic            full_hit;
    logic            clear;
    logic [ADDR_W:0] cnt_inc;

    lrck_edge_sync u_lrck_sync (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_LRCK),
        .o_rise  (tick)
    );

    assign xfer     = req_q & wr.i_wr_ack;
    assign cnt_inc  = cnt_q + (ADDR_W + 1)'(1);
    assign full_hit = xfer && (cnt_inc == MaxCnt);
    assign capture  = (state_q == StRec) &&
                      ((CAPTURE_DLY == 1) ? tick : (dly_q == DlyW'(1)));

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        req_d        = req_q;
        addr_d       = addr_q;
        data_d       = data_q;
        cnt_d        = cnt_q;
        full_d       = full_q;
        overrun_d    = overrun_q;
        start_pend_d = 1'b0;
        clear        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (i_start && !i_pause && !i_stop) begin
                    state_d = StArm;
                    clear   = 1'b1;
                end
            end
            StArm: begin
                if (i_stop) begin
                    state_d = StDone;
                end else if (tick) begin
                    state_d = StRec;
                end
            end
            StRec: begin
                if (i_stop || full_hit) begin
                    state_d = StDone;
                end else if (i_pause) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (i_stop || full_hit) begin
                    state_d = StDone;
                end else if (i_start) begin
                    state_d = StRec;
                end
            end
            StDone: begin
                // A restart must not clear the address under an outstanding write.
                if (!i_stop && ((i_start && !i_pause) || start_pend_q)) begin
                    if (req_q) begin
                        start_pend_d = 1'b1;
                    end else begin
                        state_d = StArm;
                        clear   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q == StRec) begin
            if (tick) begin
                dly_d = DlyLoad;
            end else if (dly_q != '0) begin
                dly_d = dly_q - DlyW'(1);
            end
        end else begin
            dly_d = '0;
        end

        if (xfer) begin
            req_d = 1'b0;
            cnt_d = cnt_inc;
            if (full_hit) begin
                full_d = 1'b1;
            end else begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        if (capture) begin
            if (req_q) begin
                overrun_d = 1'b1;
            end else begin
                req_d  = 1'b1;
                data_d = i_sample;
            end
        end

        if (clear) begin
            addr_d    = '0;
            cnt_d     = '0;
            full_d    = 1'b0;
            overrun_d = 1'b0;
        end

        rec_en_d = (state_d == StArm) || (state_d == StRec) || (state_d == StPause);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= StIdle;
            dly_q        <= '0;
            req_q        <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            cnt_q        <= '0;
            full_q       <= 1'b0;
            overrun_q    <= 1'b0;
            rec_en_q     <= 1'b0;
            start_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dly_q        <= dly_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            cnt_q        <= cnt_d;
            full_q       <= full_d;
            overrun_q    <= overrun_d;
            rec_en_q     <= rec_en_d;
            start_pend_q <= start_pend_d;
        end
    end

    assign o_state      = state_q;
    assign o_rec_en     = rec_en_q;
    assign o_sample_cnt = cnt_q;
    assign o_full       = full_q;
    assign o_overrun    = overrun_q;
    assign wr.o_wr_req  = req_q;
    assign wr.o_wr_addr = addr_q;
    assign wr.o_wr_data = data_q;

endmodule
